reflet_ram_wide: RTL and testbench
==================================

// Module: reflet_ram_wide
// PURPOSE
//   Parametrised single-port RAM for the Reflet controller. Generalises the 8-bit RAM to any
//   multiple-of-8 word width, with per-byte write masks and a registered read port.
//   Replaces the one-cycle bulk clear with a sequential clear engine that zeroes one word
//   per cycle, and reports availability on a ready flag.
//   Sits between the CPU/bus decoder and on-chip storage; the decoder drives enable per region.
// PARAMETERS
//   wordSize  16   data width in bits; must be a multiple of 8 (byte lanes = wordSize/8)
//   addrSize  8    address width in bits
//   size      256  number of words implemented; must be <= 2**addrSize
// PORTS
//   clk        in   1            system clock, all logic on rising edge
//   reset      in   1            synchronous, active-high reset
//   enable     in   1            access strobe from bus decoder
//   addr       in   addrSize     word address
//   data_in    in   wordSize     write data
//   write_en   in   1            1 = write, 0 = read
//   byte_mask  in   wordSize/8   per-lane write enable; bit i covers data bits [8i+7:8i]
//   data_out   out  wordSize     registered read data
//   ready      out  1            1 = clear done, accesses accepted
//   oob        out  1            registered pulse: previous access hit addr >= size
// BEHAVIOUR
//   States: CLEAR, RUN. The clear pointer clr_ptr (addrSize bits) is internal.
//   Reset (reset=1 on an edge):
//     - state <= CLEAR, clr_ptr <= 0
//     - data_out <= 0, ready <= 0, oob <= 0
//     - Memory contents are not touched by reset itself.
//   CLEAR:
//     - Each cycle writes 0 to mem[clr_ptr] (all lanes), then clr_ptr <= clr_ptr + 1.
//     - When clr_ptr == size-1 is written, state <= RUN and ready <= 1 on the same edge.
//     - Total size cycles from reset deassertion to ready=1.
//     - All bus inputs are ignored. data_out stays 0 and oob stays 0.
//     - Reset asserted mid-clear restarts the sweep at address 0.
//   RUN, with usable = enable && (addr < size):
//     - Write (usable & write_en): each lane i with byte_mask[i]=1 is updated; other lanes keep
//       their old value. byte_mask = 0 is a legal no-op write.
//     - Read data is 1-cycle latency: data_out <= mem[addr] after the write on the same edge
//       (write-first). A write cycle therefore returns the merged new word.
//     - If usable = 0: data_out <= 0 next edge and no memory change.
//     - oob <= enable && (addr >= size) each edge; a dropped out-of-range write also raises oob.
//     - The RUN state holds until reset. There is no other return path to CLEAR.
//   Comparison addr < size is unsigned at full addrSize width.
//   Memory stays inferable as block RAM: one read and one masked write per cycle, and no
//   bulk loops.
// TESTING
//   - Clear timing: reset 1 cycle, then count edges
//     -> ready=1 exactly size (256) cycles later; data_out=0 throughout.
//   - Masked write, wordSize=16: write 0xABCD to addr 5; then write 0x1234 with mask 2'b10;
//     then read addr 5 -> data_out=0x12CD one cycle after the read.
//   - Write-first: write 0xBEEF to addr 9, mask 2'b11
//     -> data_out=0xBEEF on the edge after the write.
//   - Out of range, size=200: write 0x5555 to addr 210
//     -> oob=1 for 1 cycle, data_out=0; a later read of addr 210 % 200 = 10 returns 0.
//   - Enable low: enable=0, write_en=1, addr 3 -> mem[3] unchanged (reads 0), data_out=0, oob=0.
//   - Reset mid-clear: assert reset at clr_ptr=100 after writing mem[50]=0x7777
//     -> ready stays 0 a further 256 cycles; a read of addr 50 then returns 0.

Source files
------------

// File: rtl/reflet_ram_wide.sv
// Single-port RAM with byte-lane write masks, write-first registered read and a
// one-word-per-cycle clear sweep that runs after every reset.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   CLEAR | zeroing mem[clr_ptr] each cycle, bus ignored, ready low
//   RUN   | normal accesses accepted, ready high until next reset
module reflet_ram_wide #(
   parameter int wordSize = 16,
   parameter int addrSize = 8,
   parameter int size     = 256
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [addrSize-1:0]     addr,
   input  logic [wordSize-1:0]     data_in,
   input  logic                    write_en,
   input  logic [wordSize/8-1:0]   byte_mask,
   output logic [wordSize-1:0]     data_out,
   output logic                    ready,
   output logic                    oob
);

   localparam int                  lanes     = wordSize / 8;
   localparam logic [addrSize:0]   size_w    = (addrSize + 1)'(size);
   localparam logic [addrSize-1:0] last_addr = addrSize'(size - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                state;
   logic [addrSize-1:0]   clr_ptr;
   logic [addrSize-1:0]   wr_addr;
   logic [wordSize-1:0]   wr_data;
   logic [lanes-1:0]      wr_lanes;
   logic [wordSize-1:0]   rd_word;
   logic [wordSize-1:0]   merged;
   logic                  in_range;
   logic                  usable;

   logic [wordSize-1:0]   mem [size];

   // Extra MSB so size == 2**addrSize still compares correctly.
   assign in_range = {1'b0, addr} < size_w;
   assign usable   = enable && in_range;
   assign rd_word  = mem[addr];

   always_comb begin
      merged = rd_word;
      for (int i = 0; i < lanes; i++) begin
         if (byte_mask[i]) merged[8*i +: 8] = data_in[8*i +: 8];
      end
   end

   // Clear sweep and bus writes share the single masked write port.
   always_comb begin
      wr_addr  = clr_ptr;
      wr_data  = '0;
      wr_lanes = '0;
      if (!reset) begin
         if (state == CLEAR) begin
            wr_lanes = '1;
         end else if (usable && write_en) begin
            wr_addr  = addr;
            wr_data  = data_in;
            wr_lanes = byte_mask;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < lanes; i++) begin
         if (wr_lanes[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= CLEAR;
         clr_ptr  <= '0;
         data_out <= '0;
         ready    <= 1'b0;
         oob      <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_ptr  <= clr_ptr + 1'b1;
               data_out <= '0;
               oob      <= 1'b0;
               if (clr_ptr == last_addr) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               oob <= enable && !in_range;
               if (!usable)       data_out <= '0;
               else if (write_en) data_out <= merged;
               else               data_out <= rd_word;
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_reflet_ram_wide.sv
// Bench for reflet_ram_wide: a full-range instance (size 256) and a partial one
// (size 200) share stimulus and are compared against a word-level reference model.
module tb_reflet_ram_wide;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [7:0]  addr;
   logic [15:0] data_in;
   logic        write_en;
   logic [1:0]  byte_mask;

   logic [15:0] dout [2];
   logic        rdy  [2];
   logic        oobv [2];

   int          passes = 0;
   int          total  = 0;

   // reference model, index 0 = size 256, index 1 = size 200
   int          sz     [2] = '{256, 200};
   logic [15:0] m_mem  [2][256];
   int          m_cnt  [2];
   logic        m_ready[2];
   logic [15:0] m_dout [2];
   logic        m_oob  [2];

   always #5 clk = ~clk;

   reflet_ram_wide #(.wordSize(16), .addrSize(8), .size(256)) dut_full (
      .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_in(data_in),
      .write_en(write_en), .byte_mask(byte_mask),
      .data_out(dout[0]), .ready(rdy[0]), .oob(oobv[0]));

   reflet_ram_wide #(.wordSize(16), .addrSize(8), .size(200)) dut_part (
      .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_in(data_in),
      .write_en(write_en), .byte_mask(byte_mask),
      .data_out(dout[1]), .ready(rdy[1]), .oob(oobv[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_cnt[k] = 0; m_ready[k] = 1'b0; m_dout[k] = '0; m_oob[k] = 1'b0;
         end else if (!m_ready[k]) begin
            m_cnt[k]++;
            m_dout[k] = '0;
            m_oob[k]  = 1'b0;
            if (m_cnt[k] == sz[k]) begin
               m_ready[k] = 1'b1;
               for (int j = 0; j < 256; j++) m_mem[k][j] = '0;
            end
         end else begin
            logic use_it;
            use_it = enable && (int'(addr) < sz[k]);
            if (use_it && write_en) begin
               if (byte_mask[0]) m_mem[k][addr][7:0]  = data_in[7:0];
               if (byte_mask[1]) m_mem[k][addr][15:8] = data_in[15:8];
            end
            m_dout[k] = use_it ? m_mem[k][addr] : 16'h0;
            m_oob[k]  = enable && (int'(addr) >= sz[k]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("data_out[%0d]", k), 32'(dout[k]), 32'(m_dout[k]));
         chk($sformatf("ready[%0d]", k),    32'(rdy[k]),  32'(m_ready[k]));
         chk($sformatf("oob[%0d]", k),      32'(oobv[k]), 32'(m_oob[k]));
      end
   endtask

   task automatic op(input logic en, input logic we, input logic [7:0] a,
                     input logic [15:0] d, input logic [1:0] m);
      enable = en; write_en = we; addr = a; data_in = d; byte_mask = m;
      tick();
   endtask

   task automatic rand_inputs();
      enable    = 1'($urandom);
      write_en  = 1'($urandom);
      addr      = 8'($urandom);
      data_in   = 16'($urandom);
      byte_mask = 2'($urandom);
   endtask

   // Runs cycles with random bus activity until the full instance is ready.
   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!rdy[0] && n < 400) begin
         rand_inputs();
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'd256);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; write_en = 1'b0; addr = '0;
      data_in = '0; byte_mask = '0;
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_ready[k] = 1'b0; m_dout[k] = '0; m_oob[k] = 1'b0;
      end
      tick();
      tick();
      reset = 1'b0;
      wait_ready("clear_cycles");

      // masked write
      op(1, 1, 8'd5, 16'hABCD, 2'b11);
      op(1, 1, 8'd5, 16'h1234, 2'b10);
      op(1, 0, 8'd5, 16'h0000, 2'b00);
      chk("masked_read", 32'(dout[0]), 32'h12CD);

      // write-first
      op(1, 1, 8'd9, 16'hBEEF, 2'b11);
      chk("write_first", 32'(dout[0]), 32'hBEEF);

      // zero mask is a no-op write that still returns the stored word
      op(1, 1, 8'd9, 16'h0000, 2'b00);
      chk("mask_zero", 32'(dout[1]), 32'hBEEF);

      // out of range on the size-200 instance
      op(1, 1, 8'd210, 16'h5555, 2'b11);
      chk("oob_pulse", 32'(oobv[1]), 32'd1);
      chk("oob_dout", 32'(dout[1]), 32'h0);
      op(1, 0, 8'd10, 16'h0000, 2'b00);
      chk("oob_pulse_end", 32'(oobv[1]), 32'd0);
      chk("oob_no_alias", 32'(dout[1]), 32'h0);

      // enable low
      op(0, 1, 8'd3, 16'hFFFF, 2'b11);
      op(1, 0, 8'd3, 16'h0000, 2'b00);
      chk("enable_low", 32'(dout[0]), 32'h0);

      // boundary addresses
      op(1, 1, 8'd199, 16'hC0DE, 2'b11);
      op(1, 1, 8'd200, 16'hD00D, 2'b11);
      op(1, 1, 8'd255, 16'hF00F, 2'b01);
      chk("last_lane_only", 32'(dout[0]), 32'h000F);
      op(1, 0, 8'd199, 16'h0000, 2'b00);
      chk("last_valid", 32'(dout[1]), 32'hC0DE);

      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         if (i % 3 == 0) write_en = 1'b0;
         tick();
      end

      // reset in the middle of a clear sweep
      op(1, 1, 8'd50, 16'h7777, 2'b11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         rand_inputs();
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_ready("clear_restart_cycles");
      op(1, 0, 8'd50, 16'h0000, 2'b00);
      chk("cleared_after_restart", 32'(dout[0]), 32'h0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
